key_schedule_seq: RTL and testbench



---
 rtl/key_schedule_seq_if.sv | 26 ++
 rtl/key_schedule_seq.sv | 197 +++++++++++++++++++
 tb/tb_key_schedule_seq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_seq_if.sv
// Request/status/read-port bundle for key_schedule_seq.
// master drives the key request and round-key index; slave is the expansion engine.
interface key_schedule_seq_if #(
    parameter int NK_MAX = 8
);
    logic                 start;
    logic [1:0]           key_len;
    logic [32*NK_MAX-1:0] key;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [3:0]           nr;
    logic [3:0]           rk_avail;
    logic [3:0]           rk_idx;
    logic [127:0]         rk_data;

    modport master (
        output start, key_len, key, rk_idx,
        input  busy, done, err, nr, rk_avail, rk_data
    );

    modport slave (
        input  start, key_len, key, rk_idx,
        output busy, done, err, nr, rk_avail, rk_data
    );
endinterface

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per clock into a 60-word round-key buffer.
// Optional feature macro KEYSCHED_EARLY_READ_EN: round keys become readable while expansion is still running.
module key_schedule_seq #(
    parameter int NK_MAX = 8
) (
    input logic               clk,
    input logic               rst,
    key_schedule_seq_if.slave bus
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

    state_t         state;
    state_t         state_next;

    logic [3:0]     key_nk;
    logic           mode_ok;
    logic           accept;
    logic           reject;

    logic [3:0]     nk;
    logic [5:0]     word_idx;
    logic [5:0]     last_idx;
    logic [2:0]     phase;
    logic [7:0]     rcon;
    logic [3:0]     nr_q;
    logic [3:0]     avail_q;
    logic           err_q;
    logic [127:0]   rk_data_q;
    logic           rd_ok;

    // Sliding window of the last Nk schedule words: win[0] = w[i-Nk], win[Nk-1] = w[i-1].
    logic [31:0]    win [NK_MAX];
    logic [31:0]    rk_mem [15][4];

    logic [31:0]    prev_word;
    logic [31:0]    temp_word;
    logic [31:0]    new_word;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        key_nk = 4'd0;
        case (bus.key_len)
            2'b00:   key_nk = 4'd4;
            2'b01:   key_nk = 4'd6;
            2'b10:   key_nk = 4'd8;
            default: key_nk = 4'd0;
        endcase
    end

    assign mode_ok  = (key_nk != 4'd0) && (int'(key_nk) <= NK_MAX);
    assign last_idx = {nk, 2'b00} + 6'd27;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (mode_ok) begin
                        accept     = 1'b1;
                        state_next = LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            LOAD:    state_next = GEN;
            GEN:     if (word_idx == last_idx) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prev_word = win[0];
        for (int k = 1; k < NK_MAX; k++) begin
            if (k == int'(nk) - 1) prev_word = win[k];
        end
    end

    always_comb begin
        temp_word = prev_word;
        if (phase == 3'd0) begin
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        end else if (nk == 4'd8 && phase == 3'd4) begin
            temp_word = sub_word(prev_word);
        end
        new_word = win[0] ^ temp_word;
    end

    assign rd_ok = (bus.rk_idx <= nr_q) && (bus.rk_idx < avail_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            nk        <= 4'd0;
            word_idx  <= 6'd0;
            phase     <= 3'd0;
            rcon      <= 8'h00;
            nr_q      <= 4'd0;
            avail_q   <= 4'd0;
            err_q     <= 1'b0;
            rk_data_q <= '0;
        end else begin
            err_q     <= reject;
            rk_data_q <= rd_ok ? {rk_mem[bus.rk_idx][0], rk_mem[bus.rk_idx][1],
                                  rk_mem[bus.rk_idx][2], rk_mem[bus.rk_idx][3]} : '0;
            if (accept) begin
                nk      <= key_nk;
                avail_q <= 4'd0;
            end
            if (state == LOAD) begin
                nr_q     <= nk + 4'd6;
                word_idx <= {2'b00, nk};
                phase    <= 3'd0;
                rcon     <= 8'h01;
`ifdef KEYSCHED_EARLY_READ_EN
                avail_q  <= nk >> 2;
`endif
            end
            if (state == GEN) begin
                word_idx <= word_idx + 6'd1;
                phase    <= (phase == 3'(nk - 4'd1)) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0) begin
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end
`ifdef KEYSCHED_EARLY_READ_EN
                if (word_idx[1:0] == 2'b11) avail_q <= avail_q + 4'd1;
`else
                if (word_idx == last_idx) avail_q <= nr_q + 4'd1;
`endif
            end
        end
    end

    // NOTE: the key window and round-key buffer are not reset; rk_avail = 0 keeps stale contents unreadable.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NK_MAX; k++) begin
                win[k] <= bus.key[32*NK_MAX-1-32*k -: 32];
            end
        end
        if (state == LOAD) begin
            for (int k = 0; k < NK_MAX; k++) begin
                if (k < int'(nk)) rk_mem[k/4][k%4] <= win[k];
            end
        end
        if (state == GEN) begin
            rk_mem[word_idx[5:2]][word_idx[1:0]] <= new_word;
            for (int k = 0; k < NK_MAX - 1; k++) begin
                win[k] <= win[k+1];
            end
            for (int k = 0; k < NK_MAX; k++) begin
                if (k == int'(nk) - 1) win[k] <= new_word;
            end
        end
    end

    assign bus.busy     = (state == LOAD) || (state == GEN);
    assign bus.done     = (state == DONE);
    assign bus.err      = err_q;
    assign bus.nr       = nr_q;
    assign bus.rk_avail = avail_q;
    assign bus.rk_data  = rk_data_q;
endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: FIPS-197 vectors plus random keys against a FIPS-level reference model.
// Expected rk_avail behaviour follows KEYSCHED_EARLY_READ_EN when it is defined for the build.
module tb_key_schedule_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    key_schedule_seq_if #(.NK_MAX(8)) bus ();
    key_schedule_seq_if #(.NK_MAX(4)) bus4 ();

    key_schedule_seq #(.NK_MAX(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    key_schedule_seq #(.NK_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  sb [256];
    logic [31:0] exp_w [60];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic build_model(input int nk, input logic [255:0] k);
        int          nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) exp_w[i] = k[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int idx);
        return {exp_w[4*idx], exp_w[4*idx+1], exp_w[4*idx+2], exp_w[4*idx+3]};
    endfunction

    // Readable round keys e cycles after the accepting edge.
    function automatic int exp_avail(input int e, input int nk);
`ifdef KEYSCHED_EARLY_READ_EN
        int written;
        if (e == 0) return 0;
        written = nk + e - 1;
        if (written > 4 * (nk + 7)) written = 4 * (nk + 7);
        return written / 4;
`else
        return (e == 4 * (nk + 7) - nk + 1) ? nk + 7 : 0;
`endif
    endfunction

    task automatic read_check(input string tag, input int idx, input logic [127:0] exp);
        bus.rk_idx = 4'(idx);
        step();
        check(tag, bus.rk_data, exp);
    endtask

    task automatic run_expand(input string tag, input logic [1:0] kl, input logic [255:0] k);
        int           nk;
        int           last;
        int           idx;
        bit           pend;
        logic [127:0] pend_exp;
        nk   = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
        last = 4 * (nk + 7) - nk + 1;
        build_model(nk, k);
        bus.key_len = kl;
        bus.key     = k;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        pend      = 1'b0;
        pend_exp  = '0;
        for (int e = 0; e <= last; e++) begin
            if (pend) check({tag, " rd"}, bus.rk_data, pend_exp);
            check({tag, " busy"}, bus.busy, (e < last));
            check({tag, " done"}, bus.done, (e == last));
            check({tag, " err"}, bus.err, 1'b0);
            check({tag, " avail"}, bus.rk_avail, exp_avail(e, nk));
            if (e >= 1) check({tag, " nr"}, bus.nr, nk + 6);
            idx        = $urandom_range(15, 0);
            pend_exp   = (idx < exp_avail(e, nk)) ? exp_rk(idx) : '0;
            bus.rk_idx = 4'(idx);
            pend       = 1'b1;
            bus.start  = (e == 3 || e == 6);
            if (e == 3) bus.key_len = 2'b11;
            if (e == 6) begin
                bus.key_len = 2'($urandom_range(2, 0));
                bus.key     = {$urandom(), $urandom(), $urandom(), $urandom(),
                               $urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (e < last) step();
        end
        bus.start = 1'b0;
        step();
        check({tag, " rd"}, bus.rk_data, pend_exp);
        check({tag, " busy after"}, bus.busy, 1'b0);
        check({tag, " done after"}, bus.done, 1'b0);
        check({tag, " avail after"}, bus.rk_avail, nk + 7);
    endtask

    task automatic reject(input string tag, input logic [1:0] kl);
        bus.key_len = kl;
        bus.key     = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        check({tag, " err"}, bus.err, 1'b1);
        check({tag, " busy"}, bus.busy, 1'b0);
        step();
        check({tag, " err clear"}, bus.err, 1'b0);
        check({tag, " busy idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic [255:0] k;
        logic [1:0]   kl;
        int           nk;
        int           idx;
        int           cnt;

        bus.start    = 1'b0;
        bus.key_len  = 2'b00;
        bus.key      = '0;
        bus.rk_idx   = 4'd0;
        bus4.start   = 1'b0;
        bus4.key_len = 2'b00;
        bus4.key     = '0;
        bus4.rk_idx  = 4'd0;
        build_sbox();

        rst = 1'b1;
        repeat (3) step();
        check("rst busy", bus.busy, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst err", bus.err, 1'b0);
        check("rst nr", bus.nr, 4'd0);
        check("rst avail", bus.rk_avail, 4'd0);
        check("rst rk_data", bus.rk_data, 128'h0);
        check("rst nk4 busy", bus4.busy, 1'b0);
        rst = 1'b0;
        step();

        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run_expand("aes128", 2'b00, k);
        check("aes128 nr", bus.nr, 4'd10);
        read_check("aes128 rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_check("aes128 rk0", 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_check("aes128 rk11", 11, 128'h0);
        read_check("aes128 rk15", 15, 128'h0);

        reject("rej11", 2'b11);
        check("rej11 nr", bus.nr, 4'd10);
        read_check("rej11 rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        k = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0123456789abcdef};
        run_expand("aes192", 2'b01, k);
        check("aes192 nr", bus.nr, 4'd12);
        read_check("aes192 rk12", 12, 128'he98ba06f448c773c8ecc720401002202);
        read_check("aes192 rk13", 13, 128'h0);

        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run_expand("aes256", 2'b10, k);
        check("aes256 nr", bus.nr, 4'd14);
        read_check("aes256 rk14", 14, 128'hfe4890d1e6188d0b046df344706c631e);
        read_check("aes256 rk1", 1, 128'h1f352c073b6108d72d9810a30914dff4);

        for (int n = 0; n < 6; n++) begin
            kl = 2'($urandom_range(2, 0));
            k  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            run_expand("rand", kl, k);
            nk = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
            for (int r = 0; r < 3; r++) begin
                idx = $urandom_range(nk + 6, 0);
                read_check("rand rk", idx, exp_rk(idx));
            end
        end

        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        bus.key_len = 2'b00;
        bus.key     = k;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (20) step();
        check("midgen busy", bus.busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", bus.busy, 1'b0);
        check("midrst done", bus.done, 1'b0);
        check("midrst avail", bus.rk_avail, 4'd0);
        check("midrst nr", bus.nr, 4'd0);
        check("midrst rk_data", bus.rk_data, 128'h0);
        read_check("midrst rd", 10, 128'h0);
        run_expand("rerun128", 2'b00, k);
        read_check("rerun128 rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        bus4.key_len = 2'b10;
        bus4.start   = 1'b1;
        step();
        bus4.start = 1'b0;
        check("nk4 rej256 err", bus4.err, 1'b1);
        check("nk4 rej256 busy", bus4.busy, 1'b0);
        step();
        check("nk4 rej256 err clear", bus4.err, 1'b0);

        bus4.key_len = 2'b00;
        bus4.key     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bus4.start   = 1'b1;
        step();
        bus4.start = 1'b0;
        cnt = 0;
        while (bus4.done !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
        check("nk4 latency", cnt, 41);
        bus4.rk_idx = 4'd10;
        step();
        check("nk4 rk10", bus4.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        bus4.key_len = 2'b01;
        bus4.start   = 1'b1;
        step();
        bus4.start = 1'b0;
        check("nk4 rej192 err", bus4.err, 1'b1);
        check("nk4 rej192 busy", bus4.busy, 1'b0);
        check("nk4 rej192 nr", bus4.nr, 4'd10);
        step();
        check("nk4 rej192 rk10", bus4.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
